// File: rtl/full_adder_pkg.sv
// rtl/full_adder_pkg.sv - shared constants and result record for the ripple-carry adder
//
// Contents:
//   FA_WIDTH_DEFAULT : default operand width (classic 1-bit full adder)
//   FA_WIDTH_MAX     : widest supported operand
//   fa_result_t      : {carry, sum} record, sum sized for the widest operand

package full_adder_pkg;

   localparam int FA_WIDTH_DEFAULT = 1;
   localparam int FA_WIDTH_MAX     = 64;

   typedef struct packed {
      logic                    carry;
      logic [FA_WIDTH_MAX-1:0] sum;
   } fa_result_t;

endpackage

// File: rtl/full_adder_bit.sv
// rtl/full_adder_bit.sv - combinational 1-bit full-adder cell
//
// Ports:
//   x, y  : operand bits
//   cin   : carry into this bit
//   s     : sum bit
//   cout  : carry out of this bit

module full_adder_bit (
   input  logic x,
   input  logic y,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = x ^ y ^ cin;
   assign cout = (x & y) | (cin & (x ^ y));

endmodule

// File: rtl/full_adder_core.sv
// rtl/full_adder_core.sv - registered N-bit ripple-carry adder built from full_adder_bit cells
//
// Parameters:
//   WIDTH      : operand width, 1..FA_WIDTH_MAX
// Ports:
//   i_clk      : clock, rising edge
//   i_rst      : asynchronous active-high reset
//   i_valid    : qualifies i_x, i_y, i_carry
//   i_x, i_y   : unsigned operands
//   i_carry    : carry-in
//   o_valid    : o_sum/o_carry hold a fresh result this cycle
//   o_sum      : registered sum modulo 2^WIDTH
//   o_carry    : registered carry-out
//   o_overflow : registered signed overflow (only with FULL_ADDER_OVERFLOW_EN)

module full_adder_core
   import full_adder_pkg::*;
#(
   parameter int WIDTH = FA_WIDTH_DEFAULT
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_valid,
   input  logic [WIDTH-1:0] i_x,
   input  logic [WIDTH-1:0] i_y,
   input  logic             i_carry,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_sum,
   output logic             o_carry
`ifdef FULL_ADDER_OVERFLOW_EN
   ,
   output logic             o_overflow
`endif
);

   // c[k] is the carry into bit k; c[WIDTH] is the final carry-out.
   logic [WIDTH:0]   c;
   logic [WIDTH-1:0] s;
   fa_result_t       res;

   assign c[0] = i_carry;

   for (genvar k = 0; k < WIDTH; k++) begin : g_bit
      full_adder_bit u_bit (
         .x    (i_x[k]),
         .y    (i_y[k]),
         .cin  (c[k]),
         .s    (s[k]),
         .cout (c[k+1])
      );
   end

   // The record is sized for the widest adder; bits above WIDTH stay zero.
   always_comb begin
      res                = '0;
      res.carry          = c[WIDTH];
      res.sum[WIDTH-1:0] = s;
   end

   if (WIDTH < FA_WIDTH_MAX) begin : g_pad
      logic unused_hi;
      assign unused_hi = ^res.sum[FA_WIDTH_MAX-1:WIDTH];
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_valid <= 1'b0;
         o_sum   <= '0;
         o_carry <= 1'b0;
      end else begin
         o_valid <= i_valid;
         if (i_valid) begin
            o_sum   <= res.sum[WIDTH-1:0];
            o_carry <= res.carry;
         end
      end
   end

`ifdef FULL_ADDER_OVERFLOW_EN
   // Signed overflow: carry into the MSB differs from carry out of it.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_overflow <= 1'b0;
      end else if (i_valid) begin
         o_overflow <= c[WIDTH] ^ c[WIDTH-1];
      end
   end
`endif

endmodule

// File: tb/tb_full_adder_core.sv
// tb/tb_full_adder_core.sv - self-checking bench for full_adder_core at WIDTH 1, 8 and 16

module tb_full_adder_core;

   logic i_clk;
   logic i_rst;

   logic        v1, c1, ov1, oc1;
   logic [0:0]  x1, y1, os1;
   logic        v8, c8, ov8, oc8;
   logic [7:0]  x8, y8, os8;
   logic        v16, c16, ov16, oc16;
   logic [15:0] x16, y16, os16;
`ifdef FULL_ADDER_OVERFLOW_EN
   logic        of1, of8, of16;
`endif

   int n_checks;
   int n_fail;

   full_adder_core #(.WIDTH(1)) dut1 (
      .i_clk (i_clk), .i_rst (i_rst), .i_valid (v1),
      .i_x (x1), .i_y (y1), .i_carry (c1),
      .o_valid (ov1), .o_sum (os1), .o_carry (oc1)
`ifdef FULL_ADDER_OVERFLOW_EN
      , .o_overflow (of1)
`endif
   );

   full_adder_core #(.WIDTH(8)) dut8 (
      .i_clk (i_clk), .i_rst (i_rst), .i_valid (v8),
      .i_x (x8), .i_y (y8), .i_carry (c8),
      .o_valid (ov8), .o_sum (os8), .o_carry (oc8)
`ifdef FULL_ADDER_OVERFLOW_EN
      , .o_overflow (of8)
`endif
   );

   full_adder_core #(.WIDTH(16)) dut16 (
      .i_clk (i_clk), .i_rst (i_rst), .i_valid (v16),
      .i_x (x16), .i_y (y16), .i_carry (c16),
      .o_valid (ov16), .o_sum (os16), .o_carry (oc16)
`ifdef FULL_ADDER_OVERFLOW_EN
      , .o_overflow (of16)
`endif
   );

   initial begin
      i_clk = 1'b0;
      forever #10 i_clk = ~i_clk;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: unsigned sum in plain integer arithmetic, overflow from operand/result signs.
   function automatic logic [64:0] ref_sum(input longint unsigned a, input longint unsigned b,
                                          input logic cin, input int w);
      longint unsigned mask;
      logic [64:0]     t;
      mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
      t    = 65'(a & mask) + 65'(b & mask) + 65'(cin);
      return t;
   endfunction

   function automatic logic ref_ovf(input longint unsigned a, input longint unsigned b,
                                    input longint unsigned r, input int w);
      logic sa, sb, sr;
      sa = a[w-1];
      sb = b[w-1];
      sr = r[w-1];
      return (sa == sb) && (sr != sa);
   endfunction

   initial begin
      logic [64:0] e;
      logic [2:0]  combo;
      n_checks = 0;
      n_fail   = 0;
      i_rst = 1'b1;
      v1 = 0; x1 = 0; y1 = 0; c1 = 0;
      v8 = 0; x8 = 0; y8 = 0; c8 = 0;
      v16 = 0; x16 = 0; y16 = 0; c16 = 0;

      #1;
      chk("rst_valid8", 64'(ov8), 64'd0);
      chk("rst_sum8", 64'(os8), 64'd0);
      chk("rst_carry8", 64'(oc8), 64'd0);
      chk("rst_valid1", 64'(ov1), 64'd0);
      chk("rst_valid16", 64'(ov16), 64'd0);
      @(negedge i_clk);
      @(negedge i_clk);
      i_rst = 1'b0;

      // WIDTH=1 truth table in order 000..111 as (x, y, c)
      for (int i = 0; i < 8; i++) begin
         combo = 3'(i);
         x1 = combo[2]; y1 = combo[1]; c1 = combo[0]; v1 = 1'b1;
         @(posedge i_clk); #1;
         e = ref_sum(64'(combo[2]), 64'(combo[1]), combo[0], 1);
         chk($sformatf("w1_sum_%0d", i), 64'(os1), 64'(e[0]));
         chk($sformatf("w1_carry_%0d", i), 64'(oc1), 64'(e[1]));
         chk($sformatf("w1_valid_%0d", i), 64'(ov1), 64'd1);
`ifdef FULL_ADDER_OVERFLOW_EN
         chk($sformatf("w1_ovf_%0d", i), 64'(of1),
             64'(ref_ovf(64'(combo[2]), 64'(combo[1]), 64'(e[0]), 1)));
`endif
         @(negedge i_clk);
      end
      v1 = 1'b0;

      // WIDTH=8 directed boundaries
      x8 = 8'hFF; y8 = 8'h00; c8 = 1'b1; v8 = 1'b1;
      @(posedge i_clk); #1;
      chk("w8_ff_00_1_sum", 64'(os8), 64'h00);
      chk("w8_ff_00_1_carry", 64'(oc8), 64'd1);
      @(negedge i_clk);
      x8 = 8'h7F; y8 = 8'h01; c8 = 1'b0;
      @(posedge i_clk); #1;
      chk("w8_7f_01_sum", 64'(os8), 64'h80);
      chk("w8_7f_01_carry", 64'(oc8), 64'd0);
`ifdef FULL_ADDER_OVERFLOW_EN
      chk("w8_7f_01_ovf", 64'(of8), 64'd1);
`endif
      @(negedge i_clk);
      x8 = 8'hFF; y8 = 8'hFF; c8 = 1'b1;
      @(posedge i_clk); #1;
      chk("w8_allones_sum", 64'(os8), 64'hFF);
      chk("w8_allones_carry", 64'(oc8), 64'd1);
      @(negedge i_clk);
      x8 = 8'h00; y8 = 8'h00; c8 = 1'b0;
      @(posedge i_clk); #1;
      chk("w8_zero_sum", 64'(os8), 64'h00);
      chk("w8_zero_carry", 64'(oc8), 64'd0);

      // Hold: 0x3C, then three idle cycles with random inputs
      @(negedge i_clk);
      x8 = 8'h3C; y8 = 8'h00; c8 = 1'b0;
      @(posedge i_clk); #1;
      chk("hold_load_sum", 64'(os8), 64'h3C);
      for (int i = 0; i < 3; i++) begin
         @(negedge i_clk);
         v8 = 1'b0; x8 = 8'($urandom); y8 = 8'($urandom); c8 = 1'($urandom);
         @(posedge i_clk); #1;
         chk($sformatf("hold_sum_%0d", i), 64'(os8), 64'h3C);
         chk($sformatf("hold_valid_%0d", i), 64'(ov8), 64'd0);
         chk($sformatf("hold_carry_%0d", i), 64'(oc8), 64'd0);
      end

      // Asynchronous reset mid-cycle while holding 0xAA
      @(negedge i_clk);
      x8 = 8'hAA; y8 = 8'h00; c8 = 1'b0; v8 = 1'b1;
      @(posedge i_clk); #1;
      chk("areset_pre_sum", 64'(os8), 64'hAA);
      #4 i_rst = 1'b1;
      #1;
      chk("areset_sum", 64'(os8), 64'h00);
      chk("areset_valid", 64'(ov8), 64'd0);
      @(negedge i_clk);
      i_rst = 1'b0;
      x8 = 8'h12; y8 = 8'h34; c8 = 1'b1;
      @(posedge i_clk); #1;
      chk("post_rst_sum", 64'(os8), 64'h47);
      chk("post_rst_valid", 64'(ov8), 64'd1);

      // Reset and valid on the same edge
      @(negedge i_clk);
      i_rst = 1'b1; x8 = 8'h55; y8 = 8'h22; c8 = 1'b1; v8 = 1'b1;
      @(posedge i_clk); #1;
      chk("rst_prio_sum", 64'(os8), 64'h00);
      chk("rst_prio_valid", 64'(ov8), 64'd0);
      chk("rst_prio_carry", 64'(oc8), 64'd0);
      @(negedge i_clk);
      i_rst = 1'b0; v8 = 1'b0;

      // Random WIDTH=16, back to back
      for (int i = 0; i < 1000; i++) begin
         x16 = 16'($urandom); y16 = 16'($urandom); c16 = 1'($urandom); v16 = 1'b1;
         e = ref_sum(64'(x16), 64'(y16), c16, 16);
         @(posedge i_clk); #1;
         chk($sformatf("rnd16_%0d", i), {47'd0, oc16, os16}, 64'(e[16:0]));
         chk($sformatf("rnd16_valid_%0d", i), 64'(ov16), 64'd1);
`ifdef FULL_ADDER_OVERFLOW_EN
         chk($sformatf("rnd16_ovf_%0d", i), 64'(of16),
             64'(ref_ovf(64'(x16), 64'(y16), 64'(e[15:0]), 16)));
`endif
         @(negedge i_clk);
      end
      v16 = 1'b0;
      @(posedge i_clk); #1;
      chk("rnd16_idle_valid", 64'(ov16), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/full_adder_core.md
# full_adder_core

Registered N-bit ripple-carry full adder, built from a chain of 1-bit full-adder cells. Each valid input triple (x, y, carry-in) produces a sum and carry-out one clock later. The block is the arithmetic leaf of the adder datapath and is exercised standalone in gate-level simulation after synthesis. WIDTH=1 reproduces the classic single-bit full adder.

## Interface
Parameters:
- WIDTH, default 1: operand width in bits; legal range 1..64.

Ports:
- i_clk  input  1  clock; all state changes on the rising edge.
- i_rst  input  1  reset; asynchronous, active-high.
- i_valid  input  1  qualifies i_x, i_y and i_carry in the current cycle.
- i_x  input  WIDTH  operand A, unsigned.
- i_y  input  WIDTH  operand B, unsigned.
- i_carry  input  1  carry-in.
- o_valid  output  1  o_sum and o_carry hold a fresh result this cycle.
- o_sum  output  WIDTH  registered sum, (i_x + i_y + i_carry) mod 2^WIDTH.
- o_carry  output  1  registered carry-out, bit WIDTH of the full-precision sum.
- o_overflow  output  1  signed overflow; present only when FULL_ADDER_OVERFLOW_EN is defined.

## Operation
- Bit k uses sum = x[k] ^ y[k] ^ c[k] and cout = (x[k]&y[k]) | (c[k]&(x[k]^y[k])).
- The carry chain starts at c[0] = i_carry and runs c[k+1] = cout(k); o_carry = c[WIDTH].
- The combinational path from inputs to the output registers is pure ripple. No carry-lookahead.
- Registers update only when i_valid=1 on a rising edge:
  - o_sum and o_carry take the new result.
  - o_valid is 1.
- When i_valid=0 on a rising edge:
  - o_sum and o_carry hold their previous values.
  - o_valid is 0.
- Inputs are never X-propagated deliberately. Inputs with i_valid=0 are don't-care.
- Results are pure functions of the current inputs. There is no accumulation across cycles.

## Timing
- Latency: exactly 1 cycle. Inputs sampled at edge N appear on the outputs after edge N, with o_valid=1 for cycle N+1.
- Throughput: one result per cycle. Back-to-back valid inputs produce back-to-back valid outputs.
- Reset (asserted at any time, asynchronously): o_sum=0, o_carry=0, o_valid=0, o_overflow=0 immediately.
- Reset mid-operation: a result in flight is discarded.
- Release: on the first rising edge after i_rst deasserts, the block samples normally.
- Simultaneous reset and i_valid=1: reset wins.
- Boundary: all-ones + all-ones + 1 gives o_sum = all-ones and o_carry=1. Zero + zero + 0 gives 0/0.

## Configuration
- FULL_ADDER_OVERFLOW_EN defined:
  - Port o_overflow exists.
  - It is registered alongside o_sum with the same latency and hold rules.
  - Value is c[WIDTH] ^ c[WIDTH-1].
  - For WIDTH=1, the value is i_carry ^ carry-out.
- Undefined: the port and its register are absent. All other behaviour is identical.

## Structure
- Shared package full_adder_pkg:
  - FA_WIDTH_DEFAULT = 1.
  - FA_WIDTH_MAX = 64.
  - A typedef for the result record {carry, sum}.
- Sub-module full_adder_bit: combinational 1-bit cell with ports x, y, cin → s, cout. It is instantiated WIDTH times in a generate loop.
- The top level holds the carry chain, the output/valid registers and the optional overflow logic.
- The design must synthesise to standard-cell gates (OSU018) with no behavioural-only constructs.

## Test plan
- WIDTH=1: apply all 8 combinations in order 000..111 (x, y, c), with i_valid=1, one per 20 ns period → (sum, carry) = 00, 10, 10, 01, 10, 01, 01, 11 one cycle later.
- WIDTH=8: x=0xFF, y=0x00, c=1 → o_sum=0x00, o_carry=1. Then x=0x7F, y=0x01, c=0 → o_sum=0x80, o_carry=0, o_overflow=1 (with the macro defined).
- Hold: a valid result of 0x3C, then i_valid=0 with random inputs for 3 cycles → o_sum stays 0x3C and o_valid=0.
- Async reset: assert i_rst mid-cycle while o_sum=0xAA → outputs go to 0 before the next edge. The first valid input after release is produced normally.
- Reset priority: i_rst=1 and i_valid=1 on the same edge → outputs remain 0 and o_valid=0.
- Random: 1000 random WIDTH=16 triples → {o_carry, o_sum} equals x+y+c delayed by one cycle.
